// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage (MULT/MULTU/DIV/DIVU).
// One radix-2 step per cycle: shift-add multiply, restoring divide on magnitudes.
// Sign fix-up (and optional HI/LO accumulate) happens in the FINISH cycle.
// Optional feature macro: MULDIV_ACCUMULATE_EN enables MADD/MADDU/MSUB/MSUBU (ops 4-7).
module ex_muldiv_unit #(
   parameter int WIDTH    = 32,
   parameter int CNT_BITS = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand_1,
   input  logic [WIDTH-1:0] operand_2,
   input  logic [WIDTH-1:0] hi_in,
   input  logic [WIDTH-1:0] lo_in,
   input  logic             cancel,
   output logic             stall_req,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_zero
);
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH, S_DZERO} state_t;
   state_t state, state_nx;

   logic [CNT_BITS-1:0]  cnt;
   logic                 is_div_q, neg_a, neg_b;
   logic [WIDTH-1:0]     op1_q, mag_a, mag_b;
   logic [2*WIDTH-1:0]   acc, acc_step;
   logic [WIDTH-1:0]     hi_hold, lo_hold, res_hi, res_lo;

   // incoming request decode
   logic             in_signed, in_div, in_neg_a, in_neg_b, legal, accept;
   logic [WIDTH-1:0] in_mag_a, in_mag_b;
   assign in_signed = ~op[0];
   assign in_div    = (op[2:1] == 2'b01);
   assign in_neg_a  = in_signed & operand_1[WIDTH-1];
   assign in_neg_b  = in_signed & operand_2[WIDTH-1];
   assign in_mag_a  = in_neg_a ? -operand_1 : operand_1;
   assign in_mag_b  = in_neg_b ? -operand_2 : operand_2;
`ifdef MULDIV_ACCUMULATE_EN
   logic             acc_op_q, sub_op_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   assign legal = 1'b1;
`else
   logic unused_acc_in;
   assign unused_acc_in = ^{hi_in, lo_in};
   assign legal = ~op[2];
`endif
   assign accept = (state == S_IDLE) && start && legal && !cancel;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // next state; cancel overrides everything
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (accept) state_nx = (in_div && operand_2 == '0) ? S_DZERO : S_CALC;
         S_CALC:   if (cnt == CNT_BITS'(WIDTH-1)) state_nx = S_FINISH;
         S_FINISH: state_nx = S_IDLE;
         S_DZERO:  state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
      if (cancel) state_nx = S_IDLE;
   end

   // one iteration: multiply adds |a| into the high half then shifts right;
   // divide shifts {rem,quot} left and keeps the trial subtraction if it did not borrow
   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   mul_sum, div_trial;
   always_comb begin
      addend    = acc[0] ? mag_a : '0;
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mag_b};
      if (is_div_q)
         acc_step = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
         acc_step = {mul_sum, acc[WIDTH-1:1]};
   end

   // operand latch on accept, then iterate while in CALC
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0; is_div_q <= 1'b0; neg_a <= 1'b0; neg_b <= 1'b0;
         op1_q <= '0; mag_a <= '0; mag_b <= '0; acc <= '0;
`ifdef MULDIV_ACCUMULATE_EN
         acc_op_q <= 1'b0; sub_op_q <= 1'b0; hi_q <= '0; lo_q <= '0;
`endif
      end else if (accept) begin
         cnt      <= '0;
         is_div_q <= in_div;
         neg_a    <= in_neg_a;
         neg_b    <= in_neg_b;
         op1_q    <= operand_1;
         mag_a    <= in_mag_a;
         mag_b    <= in_mag_b;
         acc      <= in_div ? {{WIDTH{1'b0}}, in_mag_a} : {{WIDTH{1'b0}}, in_mag_b};
`ifdef MULDIV_ACCUMULATE_EN
         acc_op_q <= op[2];
         sub_op_q <= op[1];
         hi_q     <= hi_in;
         lo_q     <= lo_in;
`endif
      end else if (state == S_CALC) begin
         acc <= acc_step;
         cnt <= cnt + CNT_BITS'(1);
      end
   end

   // sign fix-up and optional accumulate; INT_MIN/-1 wraps naturally
   logic [2*WIDTH-1:0] prod, res;
   logic               fix;
   always_comb begin
      fix  = neg_a ^ neg_b;
      prod = fix ? -acc : acc;
      res  = prod;
`ifdef MULDIV_ACCUMULATE_EN
      if (acc_op_q) res = sub_op_q ? {hi_q, lo_q} - prod : {hi_q, lo_q} + prod;
`endif
      res_hi = res[2*WIDTH-1:WIDTH];
      res_lo = res[WIDTH-1:0];
      if (is_div_q) begin
         res_lo = fix   ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
         res_hi = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
   end

   // outputs: result shown in the done cycle, held afterwards
   always_comb begin
      stall_req = accept || (state == S_CALC);
      done      = (state == S_FINISH) || (state == S_DZERO);
      div_zero  = (state == S_DZERO);
      hi_out    = hi_hold;
      lo_out    = lo_hold;
      if (state == S_FINISH) begin
         hi_out = res_hi;
         lo_out = res_lo;
      end else if (state == S_DZERO) begin
         hi_out = op1_q;
         lo_out = '1;
      end
   end

   // capture the presented result so it persists until the next done
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_hold <= '0;
         lo_hold <= '0;
      end else if (done) begin
         hi_hold <= hi_out;
         lo_hold <= lo_out;
      end
   end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected results are queued at issue,
// a negedge monitor pops and compares whenever done is presented.
module tb_ex_muldiv_unit;
   localparam int W = 32;

   logic         clk = 1'b0, rst = 1'b0, start = 1'b0, cancel = 1'b0;
   logic [2:0]   op = '0;
   logic [W-1:0] operand_1 = '0, operand_2 = '0, hi_in = '0, lo_in = '0;
   logic         stall_req, done, div_zero;
   logic [W-1:0] hi_out, lo_out;

   int           pass_cnt = 0, total_cnt = 0, done_seen = 0;
   logic [64:0]  exp_q[$];
   logic [64:0]  mon_e;
   logic [W-1:0] last_hi = '0, last_lo = '0;

   ex_muldiv_unit #(.WIDTH(W), .CNT_BITS(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .operand_1(operand_1), .operand_2(operand_2), .hi_in(hi_in), .lo_in(lo_in),
      .cancel(cancel), .stall_req(stall_req), .done(done),
      .hi_out(hi_out), .lo_out(lo_out), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      total_cnt++;
      if (act === expv) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, expv);
   endtask

   // reference: {div_zero, hi, lo} from plain arithmetic
   function automatic logic [64:0] model(input logic [2:0] o, input logic [W-1:0] a, b, hi, lo);
      longint      sa, sb, q, r;
      logic [63:0] p, prod;
      logic        dz;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = 1'b0;
      p  = '0;
      case (o)
         3'd0: p = 64'(sa * sb);
         3'd1: p = {32'd0, a} * {32'd0, b};
         3'd2, 3'd3: begin
            if (b == '0) begin
               dz = 1'b1;
               p  = {a, 32'hFFFF_FFFF};
            end else if (o == 3'd2) begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end else begin
               p = {a % b, a / b};
            end
         end
         default: begin
            prod = o[0] ? ({32'd0, a} * {32'd0, b}) : 64'(sa * sb);
            p    = o[1] ? {hi, lo} - prod : {hi, lo} + prod;
         end
      endcase
      return {dz, p};
   endfunction

   // monitor: every done must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst && done) begin
         done_seen++;
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_done: got done hi=%0h lo=%0h, expected no done", hi_out, lo_out);
         end else begin
            mon_e = exp_q.pop_front();
            chk("hi_out", 64'(hi_out), 64'(mon_e[63:32]));
            chk("lo_out", 64'(lo_out), 64'(mon_e[31:0]));
            chk("div_zero", 64'(div_zero), 64'(mon_e[64]));
         end
      end
   end

   // issue one op at posedge+1, scramble inputs after the start edge, time the result
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, b, hi, lo);
      logic [64:0] e;
      int n, stalls, lat;
      e   = model(o, a, b, hi, lo);
      lat = e[64] ? 1 : W + 1;
      exp_q.push_back(e);
      op = o; operand_1 = a; operand_2 = b; hi_in = hi; lo_in = lo; start = 1'b1;
      @(negedge clk);
      stalls = stall_req ? 1 : 0;
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom);
      operand_1 = $urandom; operand_2 = $urandom; hi_in = $urandom; lo_in = $urandom;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (stall_req) stalls++;
      end while (!done && n < 100);
      chk("latency", 64'(n), 64'(lat));
      chk("stall_cycles", 64'(stalls), 64'(lat));
      last_hi = e[63:32];
      last_lo = e[31:0];
      @(posedge clk); #1;
   endtask

   function automatic logic [W-1:0] pick(input bit allow_zero);
      int k;
      k = $urandom_range(0, 9);
      case (k)
         0: return allow_zero ? 32'd0 : 32'd1;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int d0;
      repeat (3) @(negedge clk);
      chk("rst_stall", 64'(stall_req), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dz", 64'(div_zero), 64'd0);
      chk("rst_hi", 64'(hi_out), 64'd0);
      chk("rst_lo", 64'(lo_out), 64'd0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;

      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      run_op(3'd0, -32'sd3, 32'd5, 0, 0);
      run_op(3'd2, -32'sd7, 32'd2, 0, 0);
      run_op(3'd3, 32'd100, 32'd7, 0, 0);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      run_op(3'd3, 32'd5, 32'd0, 0, 0);
      run_op(3'd2, -32'sd5, 32'd0, 0, 0);
      run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 0, 0);

      // cancel on cycle 10 of a MULT: no done, outputs untouched
      d0 = done_seen;
      op = 3'd0; operand_1 = 32'd1234; operand_2 = 32'd5678; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk); #1 cancel = 1'b0;
      @(negedge clk);
      chk("cancel_idle_stall", 64'(stall_req), 64'd0);
      chk("cancel_hi_hold", 64'(hi_out), 64'(last_hi));
      chk("cancel_lo_hold", 64'(lo_out), 64'(last_lo));
      chk("cancel_no_done", 64'(done_seen), 64'(d0));
      @(posedge clk); #1;
      run_op(3'd1, 32'd6, 32'd7, 0, 0);

      // start and cancel together: nothing accepted
      d0 = done_seen;
      op = 3'd1; operand_1 = 32'd3; operand_2 = 32'd3; start = 1'b1; cancel = 1'b1;
      @(negedge clk);
      chk("startcancel_stall", 64'(stall_req), 64'd0);
      @(posedge clk); #1 start = 1'b0; cancel = 1'b0;
      repeat (40) @(negedge clk);
      chk("startcancel_no_done", 64'(done_seen), 64'(d0));
      @(posedge clk); #1;

`ifdef MULDIV_ACCUMULATE_EN
      run_op(3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
      run_op(3'd6, 32'd2, 32'd3, 32'd0, 32'd0);
      run_op(3'd4, -32'sd4, 32'd9, 32'd1, 32'd2);
      run_op(3'd7, 32'hFFFF_FFFF, 32'd2, 32'd5, 32'd0);
`else
      d0 = done_seen;
      op = 3'd4; operand_1 = 32'd2; operand_2 = 32'd3; start = 1'b1;
      @(negedge clk);
      chk("illegal_stall", 64'(stall_req), 64'd0);
      @(posedge clk); #1 start = 1'b0;
      repeat (40) @(negedge clk);
      chk("illegal_no_done", 64'(done_seen), 64'(d0));
      @(posedge clk); #1;
`endif

      // asynchronous reset mid-CALC
      op = 3'd0; operand_1 = 32'd123; operand_2 = 32'd456; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_stall", 64'(stall_req), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_hi", 64'(hi_out), 64'd0);
      chk("arst_lo", 64'(lo_out), 64'd0);
      @(posedge clk); #3 rst = 1'b1;
      @(negedge clk);
      chk("arst_idle_stall", 64'(stall_req), 64'd0);
      @(posedge clk); #1;
      run_op(3'd3, 32'd1000, 32'd33, 0, 0);

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         logic [2:0] o;
`ifdef MULDIV_ACCUMULATE_EN
         o = 3'($urandom_range(0, 7));
`else
         o = 3'($urandom_range(0, 3));
`endif
         run_op(o, pick(1'b1), pick(1'b1), $urandom, $urandom);
      end

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
